sequence_transmitter: RTL

SEQUENCE_TRANSMITTER -- requirements
Module: sequence_transmitter

---
 rtl/sequence_transmitter_if.sv | 24 ++
 rtl/sequence_transmitter.sv | 100 ++++++++++
 2 files changed

// File: rtl/sequence_transmitter_if.sv
// sequence_transmitter_if: request/pattern inputs and serial outputs of the sequence transmitter
// Ports (signals): start, pattern[MAX_LEN], len[5], repeat_i (only with SEQUENCE_TRANSMITTER_REPEAT_EN),
//                  out, valid, busy, done. master drives requests, slave is the transmitter.
interface sequence_transmitter_if #(
    parameter int MAX_LEN = 8
);
    logic               start;
    logic [MAX_LEN-1:0] pattern;
    logic [4:0]         len;
`ifdef SEQUENCE_TRANSMITTER_REPEAT_EN
    logic               repeat_i;
`endif
    logic               out;
    logic               valid;
    logic               busy;
    logic               done;
`ifdef SEQUENCE_TRANSMITTER_REPEAT_EN
    modport master (output start, pattern, len, repeat_i, input out, valid, busy, done);
    modport slave  (input start, pattern, len, repeat_i, output out, valid, busy, done);
`else
    modport master (output start, pattern, len, input out, valid, busy, done);
    modport slave  (input start, pattern, len, output out, valid, busy, done);
`endif
endinterface

// File: rtl/sequence_transmitter.sv
// sequence_transmitter: serialises a captured pattern MSB-first with valid/busy/done framing
// Ports: clk (clock), r (sync active-high reset), bus (sequence_transmitter_if.slave).
// Optional macro SEQUENCE_TRANSMITTER_REPEAT_EN adds bus.repeat_i and the GAP/resend path.
module sequence_transmitter #(
    parameter int MAX_LEN    = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  r,
    sequence_transmitter_if.slave bus
);
    localparam int CW = $clog2(MAX_LEN);
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2, DONE = 2'd3} state_t;
    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [4:0]         len_eff;
    logic               out_q, out_d, valid_q, valid_d, busy_q, busy_d, done_q, done_d;
`ifdef SEQUENCE_TRANSMITTER_REPEAT_EN
    logic [4:0]         len_q, len_d;
    logic [3:0]         gap_q, gap_d;
`endif
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        cnt_d   = cnt_q;
`ifdef SEQUENCE_TRANSMITTER_REPEAT_EN
        len_d   = len_q;
        gap_d   = gap_q;
`endif
        len_eff = (bus.len > 5'(MAX_LEN)) ? 5'(MAX_LEN) : bus.len;
        case (state_q)
            IDLE: if (bus.start && bus.len != 5'd0) begin
                state_d = SEND;
                pat_d   = bus.pattern;
                cnt_d   = CW'(len_eff - 5'd1);
`ifdef SEQUENCE_TRANSMITTER_REPEAT_EN
                len_d   = len_eff;
`endif
            end
            SEND: if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
`ifdef SEQUENCE_TRANSMITTER_REPEAT_EN
            else if (bus.repeat_i) begin
                // zero gap restarts the frame straight from the last bit
                if (GAP_CYCLES == 0) cnt_d = CW'(len_q - 5'd1);
                else begin
                    state_d = GAP;
                    gap_d   = 4'(GAP_CYCLES - 1);
                end
            end
`endif
            else state_d = DONE;
`ifdef SEQUENCE_TRANSMITTER_REPEAT_EN
            GAP: if (gap_q != 4'd0) gap_d = gap_q - 4'd1;
            else begin
                state_d = SEND;
                cnt_d   = CW'(len_q - 5'd1);
            end
`endif
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // outputs are registered from the next state so they line up with it
        valid_d = state_d == SEND;
        out_d   = valid_d ? pat_d[cnt_d] : 1'b0;
        busy_d  = state_d != IDLE;
        done_d  = state_d == DONE;
    end
    always_ff @(posedge clk) begin
        if (r) begin
            state_q <= IDLE;
            pat_q   <= '0;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SEQUENCE_TRANSMITTER_REPEAT_EN
            len_q   <= '0;
            gap_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SEQUENCE_TRANSMITTER_REPEAT_EN
            len_q   <= len_d;
            gap_q   <= gap_d;
`endif
        end
    end
    assign bus.out   = out_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule
